// File: rtl/issue_div_arbiter_pkg.sv
// Shared types and default sizing for the divide-unit issue arbiter.
package issue_div_arbiter_pkg;

  localparam int NUM_LANES   = 4;
  localparam int LANE_LOG    = 2;
  localparam int DIV_LATENCY = 16;
  localparam int PHY_LOG     = 7;

  typedef struct packed {
    logic [PHY_LOG-1:0] reg_id;
    logic               valid;
  } phys_reg;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } divArbState_t;

endpackage

// File: rtl/issue_div_arbiter_rr_arb.sv
// Combinational round-robin picker: first request at or after ptr_i, wrapping at NUM_LANES.
module issue_div_arbiter_rr_arb #(
  parameter int NUM_LANES = 4,
  parameter int LANE_LOG  = 2
) (
  input  logic [NUM_LANES-1:0] req_i,
  input  logic [LANE_LOG-1:0]  ptr_i,
  output logic [NUM_LANES-1:0] grant_o,
  output logic [LANE_LOG-1:0]  winner_o,
  output logic                 any_o
);

  logic [LANE_LOG:0]   sum;
  logic [LANE_LOG-1:0] idx;

  always_comb begin
    grant_o  = '0;
    winner_o = '0;
    any_o    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      // One extra bit lets non-power-of-two lane counts wrap at NUM_LANES-1.
      sum = {1'b0, ptr_i} + (LANE_LOG+1)'(i);
      if (sum >= (LANE_LOG+1)'(NUM_LANES)) begin
        sum = sum - (LANE_LOG+1)'(NUM_LANES);
      end
      idx = sum[LANE_LOG-1:0];
      if (!any_o && req_i[idx]) begin
        any_o        = 1'b1;
        winner_o     = idx;
        grant_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_div_arbiter.sv
// Shares one fixed-latency, non-pipelined divider among the issue lanes with
// round-robin grant, busy masking, early wakeup tag and a done pulse.
module issue_div_arbiter
  import issue_div_arbiter_pkg::*;
#(
  parameter int NUM_LANES   = issue_div_arbiter_pkg::NUM_LANES,
  parameter int LANE_LOG    = issue_div_arbiter_pkg::LANE_LOG,
  parameter int DIV_LATENCY = issue_div_arbiter_pkg::DIV_LATENCY
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush_i,
  input  logic [NUM_LANES-1:0]          laneActive_i,
  input  logic [NUM_LANES-1:0]          req_i,
  input  phys_reg [NUM_LANES-1:0]       reqDest_i,
  output logic [NUM_LANES-1:0]          grant_o,
  output logic                          divBusy_o,
  output phys_reg                       rsrTag_o,
  output logic                          done_o,
  output logic [LANE_LOG-1:0]           doneLane_o,
  output phys_reg                       doneDest_o
);

  divArbState_t        state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [LANE_LOG-1:0] rr_ptr_q, rr_ptr_d;
  logic [LANE_LOG-1:0] owner_q, owner_d;
  phys_reg             dest_q, dest_d;

  logic [NUM_LANES-1:0] e_req;
  logic [NUM_LANES-1:0] arb_grant;
  logic [LANE_LOG-1:0]  arb_winner;
  logic                 arb_any;

  assign e_req = req_i & laneActive_i;

  issue_div_arbiter_rr_arb #(
    .NUM_LANES (NUM_LANES),
    .LANE_LOG  (LANE_LOG)
  ) u_rr_arb (
    .req_i    (e_req),
    .ptr_i    (rr_ptr_q),
    .grant_o  (arb_grant),
    .winner_o (arb_winner),
    .any_o    (arb_any)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    dest_d     = dest_q;
    grant_o    = '0;
    divBusy_o  = (state_q == DIV_BUSY);
    rsrTag_o   = '0;
    done_o     = 1'b0;
    doneLane_o = '0;
    doneDest_o = '0;

    case (state_q)
      DIV_IDLE: begin
        // Grant is suppressed while reset is held so nothing looks accepted.
        if (arb_any && !flush_i && reset) begin
          grant_o  = arb_grant;
          owner_d  = arb_winner;
          dest_d   = reqDest_i[arb_winner];
          cnt_d    = 8'(DIV_LATENCY - 1);
          rr_ptr_d = (arb_winner == LANE_LOG'(NUM_LANES - 1)) ? '0
                                                              : arb_winner + LANE_LOG'(1);
          state_d  = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = 8'd0;
          state_d = DIV_IDLE;
          if (!flush_i) begin
            done_o     = 1'b1;
            doneLane_o = owner_q;
            doneDest_o = dest_q;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1 && !flush_i && dest_q.valid) begin
            rsrTag_o = dest_q;
          end
        end
      end
      default: state_d = DIV_IDLE;
    endcase

    if (flush_i) begin
      state_d = DIV_IDLE;
      cnt_d   = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= 8'd0;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      dest_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      dest_q   <= dest_d;
    end
  end

  // Lanes are expected to mask divide selects while the unit is busy.
  a_no_req_when_busy: assert property (
    @(posedge clk) disable iff (!reset)
    (state_q == DIV_BUSY) |-> !(|e_req)
  );

endmodule

// File: tb/tb_issue_div_arbiter.sv
// Randomized and directed checks of issue_div_arbiter against a cycle-indexed behavioural model.
module tb_issue_div_arbiter;
  import issue_div_arbiter_pkg::*;

  localparam int LAT = DIV_LATENCY;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush_i = 1'b0;
  logic [3:0]    laneActive_i = 4'hF;
  logic [3:0]    req_i = 4'h0;
  phys_reg [3:0] reqDest_i = '0;
  logic [3:0]    grant_o;
  logic          divBusy_o;
  phys_reg       rsrTag_o;
  logic          done_o;
  logic [1:0]    doneLane_o;
  phys_reg       doneDest_o;

  issue_div_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush_i),
    .laneActive_i (laneActive_i),
    .req_i        (req_i),
    .reqDest_i    (reqDest_i),
    .grant_o      (grant_o),
    .divBusy_o    (divBusy_o),
    .rsrTag_o     (rsrTag_o),
    .done_o       (done_o),
    .doneLane_o   (doneLane_o),
    .doneDest_o   (doneDest_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: the unit is "owned" from the grant cycle m_gt; outputs follow from elapsed cycles.
  bit      m_active = 1'b0;
  int      m_gt = 0;
  int      m_owner = 0;
  int      m_rr = 0;
  int      now = 0;
  phys_reg m_dest = '0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, a, e, now);
    end
  endtask

  task automatic cyc(input logic rst, input logic fl, input logic [3:0] act,
                     input logic [3:0] req, input bit rnd_dest);
    logic [3:0] ereq;
    logic [3:0] exp_g;
    phys_reg    exp_rsr;
    logic       exp_done;
    int         e;
    int         w;
    @(negedge clk);
    reset        = rst;
    flush_i      = fl;
    laneActive_i = act;
    req_i        = m_active ? 4'h0 : req;
    if (rnd_dest) for (int i = 0; i < 4; i++) reqDest_i[i] = 8'($urandom);
    #1;
    ereq     = req_i & act;
    exp_g    = '0;
    exp_rsr  = '0;
    w        = -1;
    e        = now - m_gt;
    if (rst && !m_active && !fl) begin
      for (int i = 0; i < 4; i++) begin
        int l;
        l = (m_rr + i) % 4;
        if (w < 0 && ereq[l]) w = l;
      end
    end
    if (w >= 0) exp_g[w] = 1'b1;
    if (rst && m_active && !fl && e == LAT - 1 && m_dest.valid) exp_rsr = m_dest;
    exp_done = rst && m_active && !fl && e == LAT;
    chk("grant", 32'(grant_o), 32'(exp_g));
    chk("busy", 32'(divBusy_o), 32'(rst && m_active));
    chk("rsr", 32'(rsrTag_o), 32'(exp_rsr));
    chk("done", 32'(done_o), 32'(exp_done));
    chk("done_lane", 32'(doneLane_o), exp_done ? 32'(m_owner) : 32'd0);
    chk("done_dest", 32'(doneDest_o), exp_done ? 32'(m_dest) : 32'd0);
    if (!rst) begin
      m_active = 1'b0;
      m_rr     = 0;
    end else if (fl) begin
      m_active = 1'b0;
    end else if (m_active && e == LAT) begin
      m_active = 1'b0;
    end else if (w >= 0) begin
      m_active = 1'b1;
      m_gt     = now;
      m_owner  = w;
      m_dest   = reqDest_i[w];
      m_rr     = (w + 1) % 4;
    end
    now++;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && m_active; k++) cyc(1'b1, 1'b0, 4'hF, 4'h0, 1'b0);
  endtask

  logic [3:0] exp_rr [5];
  logic [3:0] g_val  [8];
  int         g_time [8];
  int         g_n;

  initial begin
    // Reset held with every lane requesting.
    cyc(1'b0, 1'b0, 4'hF, 4'hF, 1'b0);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_busy", 32'(divBusy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    cyc(1'b0, 1'b0, 4'hF, 4'hF, 1'b0);
    cyc(1'b1, 1'b0, 4'hF, 4'hF, 1'b0);
    chk("rst_release_grant", 32'(grant_o), 32'h1);
    drain();

    // Single divide to lane 2, dest {37,1}.
    reqDest_i[2] = '{reg_id: 7'd37, valid: 1'b1};
    cyc(1'b1, 1'b0, 4'hF, 4'b0100, 1'b0);
    chk("single_grant", 32'(grant_o), 32'h4);
    for (int k = 1; k <= 17; k++) begin
      cyc(1'b1, 1'b0, 4'hF, 4'h0, 1'b0);
      if (k == 1)  chk("single_busy_t1", 32'(divBusy_o), 32'd1);
      if (k == 14) chk("single_rsr_t14", 32'(rsrTag_o), 32'h0);
      if (k == 15) chk("single_rsr_t15", 32'(rsrTag_o), 32'h4B);
      if (k == 16) begin
        chk("single_done", 32'(done_o), 32'd1);
        chk("single_done_lane", 32'(doneLane_o), 32'd2);
        chk("single_busy_t16", 32'(divBusy_o), 32'd1);
      end
      if (k == 17) chk("single_idle_t17", 32'(divBusy_o), 32'd0);
    end

    // Round-robin from a fresh pointer with all lanes requesting.
    cyc(1'b0, 1'b0, 4'hF, 4'h0, 1'b0);
    exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    g_n = 0;
    for (int k = 0; k < 4 * (LAT + 1) + 1; k++) begin
      cyc(1'b1, 1'b0, 4'hF, 4'hF, 1'b1);
      if (grant_o != 4'h0 && g_n < 8) begin
        g_val[g_n]  = grant_o;
        g_time[g_n] = now;
        g_n++;
      end
    end
    chk("rr_count", 32'(g_n), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("rr_grant", (i < g_n) ? 32'(g_val[i]) : 32'hFFFF, 32'(exp_rr[i]));
      if (i > 0 && i < g_n) chk("rr_spacing", 32'(g_time[i] - g_time[i-1]), 32'(LAT + 1));
    end
    drain();

    // Inactive lane's request is ignored.
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, 4'b1101, 4'b0010, 1'b0);
      chk("mask_grant", 32'(grant_o), 32'd0);
      chk("mask_busy", 32'(divBusy_o), 32'd0);
    end

    // Flush mid-operation, then regrant right after.
    cyc(1'b1, 1'b0, 4'hF, 4'b0001, 1'b1);
    for (int k = 1; k <= 7; k++) cyc(1'b1, 1'b0, 4'hF, 4'h0, 1'b0);
    cyc(1'b1, 1'b1, 4'hF, 4'h0, 1'b0);
    chk("flush_t8_done", 32'(done_o), 32'd0);
    cyc(1'b1, 1'b0, 4'hF, 4'b1000, 1'b1);
    chk("flush_t9_busy", 32'(divBusy_o), 32'd0);
    chk("flush_t9_grant", 32'(grant_o), 32'h8);
    drain();

    // Flush on the done cycle suppresses done.
    cyc(1'b1, 1'b0, 4'hF, 4'b0010, 1'b1);
    for (int k = 1; k <= 15; k++) cyc(1'b1, 1'b0, 4'hF, 4'h0, 1'b0);
    cyc(1'b1, 1'b1, 4'hF, 4'h0, 1'b0);
    chk("flush_done_cycle", 32'(done_o), 32'd0);
    cyc(1'b1, 1'b0, 4'hF, 4'h0, 1'b0);
    chk("flush_done_idle", 32'(divBusy_o), 32'd0);

    // Invalid destination still occupies the unit.
    for (int i = 0; i < 4; i++) reqDest_i[i] = '{reg_id: 7'd55, valid: 1'b0};
    cyc(1'b1, 1'b0, 4'hF, 4'b0010, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b1, 1'b0, 4'hF, 4'h0, 1'b0);
      if (k == 15) chk("inval_rsr", 32'(rsrTag_o), 32'd0);
      if (k == 16) chk("inval_done", 32'(done_o), 32'd1);
    end
    drain();

    // Asynchronous reset mid-operation.
    cyc(1'b1, 1'b0, 4'hF, 4'b0100, 1'b0);
    for (int k = 1; k <= 5; k++) cyc(1'b1, 1'b0, 4'hF, 4'h0, 1'b0);
    chk("pre_async_busy", 32'(divBusy_o), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_busy", 32'(divBusy_o), 32'd0);
    m_active = 1'b0;
    m_rr     = 0;
    cyc(1'b0, 1'b0, 4'hF, 4'h0, 1'b0);
    cyc(1'b1, 1'b0, 4'hF, 4'h0, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < 2000; k++) begin
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 19) == 0),
          4'($urandom), 4'($urandom), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
